// File: rtl/pma_loopback_channel_pkg.sv
// Shared constants, the loopback configuration record and small helpers
// for the PMA loopback channel.
package pma_loopback_channel_pkg;

  localparam int LPBK_W_DATA    = 32;
  localparam int LPBK_MAX_DELAY = 8;
  localparam int LPBK_W_PERIOD  = 16;
  localparam int LPBK_W_ERRCNT  = 16;

  typedef struct packed {
    logic [$clog2(LPBK_W_DATA)-1:0]      shift;
    logic [$clog2(LPBK_MAX_DELAY+1)-1:0] delay;
    logic [LPBK_W_PERIOD-1:0]            period;
  } lpbk_cfg_t;

  function automatic int clamp_max(input int value, input int limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/pma_loopback_channel_delay_line.sv
// Word delay line: written every cycle, read at a selectable age.
// Age 0 is the input word itself, age k is the word written k cycles ago.
module pma_delay_line #(
  parameter int W_DATA    = 32,
  parameter int MAX_DELAY = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [W_DATA-1:0]              din,
  input  logic [$clog2(MAX_DELAY+1)-1:0] age,
  output logic [W_DATA-1:0]              dout
);

  logic [W_DATA-1:0] line_r [MAX_DELAY];
  logic [W_DATA-1:0] taps_s [MAX_DELAY+1];

  // shift register of past words
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_DELAY; i++) line_r[i] <= '0;
    end else begin
      line_r[0] <= din;
      for (int i = 1; i < MAX_DELAY; i++) line_r[i] <= line_r[i-1];
    end
  end

  // tap 0 bypasses the line so zero delay adds no latency
  always_comb begin
    taps_s[0] = din;
    for (int i = 1; i <= MAX_DELAY; i++) taps_s[i] = line_r[i-1];
  end

  assign dout = taps_s[age];

endmodule

// File: rtl/pma_loopback_channel.sv
// PMA loopback channel: tx word -> bit slip -> word delay -> error injection
// -> registered rx word, with a saturating count of corrupted words.
module pma_loopback_channel
  import pma_loopback_channel_pkg::*;
#(
  parameter int W_DATA    = LPBK_W_DATA,
  parameter int MAX_DELAY = LPBK_MAX_DELAY,
  parameter int W_PERIOD  = LPBK_W_PERIOD,
  parameter int W_ERRCNT  = LPBK_W_ERRCNT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [W_DATA-1:0]              i_tx_pma_data,
  output logic [W_DATA-1:0]              o_rx_pma_data,
  input  logic                           i_cfg_load,
  input  logic [$clog2(W_DATA)-1:0]      i_cfg_shift,
  input  logic [$clog2(MAX_DELAY+1)-1:0] i_cfg_delay,
  input  logic [W_PERIOD-1:0]            i_err_period,
  input  logic                           i_err_inject,
  input  logic [$clog2(W_DATA)-1:0]      i_err_bit,
  output logic [W_ERRCNT-1:0]            o_err_count,
  output logic                           o_cfg_busy
);

  localparam int SW = $clog2(W_DATA);
  localparam int DW = $clog2(MAX_DELAY+1);
  localparam int BW = $clog2(MAX_DELAY+3);

  logic [W_DATA-1:0]   cur_r;
  logic [SW-1:0]       shift_r;
  logic [DW-1:0]       delay_r;
  logic [W_PERIOD-1:0] period_r;
  logic [W_PERIOD-1:0] ctr_r;
  logic [SW-1:0]       rot_r;
  logic [BW-1:0]       busy_cnt_r;
  logic [2*W_DATA-1:0] slip_cat_s;
  logic [W_DATA-1:0]   word_s;
  logic [W_DATA-1:0]   delayed_s;
  logic [W_DATA-1:0]   mask_s;
  logic                period_hit_s;

  // slipped word spans the previous and current tx words
  assign slip_cat_s   = {cur_r, i_tx_pma_data} >> shift_r;
  assign word_s       = slip_cat_s[W_DATA-1:0];
  assign period_hit_s = (period_r != '0) && (ctr_r == period_r - W_PERIOD'(1));

  pma_delay_line #(
    .W_DATA    (W_DATA),
    .MAX_DELAY (MAX_DELAY)
  ) u_delay_line (
    .clk   (clk),
    .reset (reset),
    .din   (word_s),
    .age   (delay_r),
    .dout  (delayed_s)
  );

  // configuration registers and busy window
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r    <= '0;
      delay_r    <= '0;
      period_r   <= '0;
      busy_cnt_r <= '0;
      o_cfg_busy <= 1'b0;
    end else if (i_cfg_load) begin
      shift_r    <= SW'(clamp_max(int'(i_cfg_shift), W_DATA-1));
      delay_r    <= DW'(clamp_max(int'(i_cfg_delay), MAX_DELAY));
      period_r   <= i_err_period;
      busy_cnt_r <= BW'(MAX_DELAY+1);
      o_cfg_busy <= 1'b1;
    end else if (busy_cnt_r != '0) begin
      busy_cnt_r <= busy_cnt_r - BW'(1);
      o_cfg_busy <= 1'b1;
    end else begin
      o_cfg_busy <= 1'b0;
    end
  end

  // periodic injection: interval counter and rotating bit index
  always_ff @(posedge clk) begin
    if (reset) begin
      ctr_r <= '0;
      rot_r <= '0;
    end else if (i_cfg_load) begin
      ctr_r <= '0;
      rot_r <= '0;
    end else if (period_hit_s) begin
      ctr_r <= '0;
      rot_r <= (rot_r == SW'(W_DATA-1)) ? SW'(0) : rot_r + SW'(1);
    end else if (period_r != '0) begin
      ctr_r <= ctr_r + W_PERIOD'(1);
    end else begin
      ctr_r <= ctr_r;
    end
  end

  // one-shot and periodic flips OR together, so a shared bit flips once
  always_comb begin
    mask_s            = '0;
    mask_s[i_err_bit] = i_err_inject;
    mask_s[rot_r]     = mask_s[rot_r] | period_hit_s;
  end

  // history, output word and saturating error counter
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_r         <= '0;
      o_rx_pma_data <= '0;
      o_err_count   <= '0;
    end else begin
      cur_r         <= i_tx_pma_data;
      o_rx_pma_data <= delayed_s ^ mask_s;
      if ((mask_s != '0) && (o_err_count != '1)) begin
        o_err_count <= o_err_count + W_ERRCNT'(1);
      end else begin
        o_err_count <= o_err_count;
      end
    end
  end

endmodule

// File: tb/tb_pma_loopback_channel.sv
// Self-checking bench for pma_loopback_channel: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_pma_loopback_channel;

  localparam int W  = 32;
  localparam int MD = 8;
  localparam int WP = 16;
  localparam int WE = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  i_tx_pma_data;
  logic [W-1:0]  o_rx_pma_data;
  logic          i_cfg_load;
  logic [4:0]    i_cfg_shift;
  logic [3:0]    i_cfg_delay;
  logic [WP-1:0] i_err_period;
  logic          i_err_inject;
  logic [4:0]    i_err_bit;
  logic [WE-1:0] o_err_count;
  logic          o_cfg_busy;

  always #5 clk = ~clk;

  pma_loopback_channel #(
    .W_DATA(W), .MAX_DELAY(MD), .W_PERIOD(WP), .W_ERRCNT(WE)
  ) dut (
    .clk(clk), .reset(reset),
    .i_tx_pma_data(i_tx_pma_data), .o_rx_pma_data(o_rx_pma_data),
    .i_cfg_load(i_cfg_load), .i_cfg_shift(i_cfg_shift), .i_cfg_delay(i_cfg_delay),
    .i_err_period(i_err_period), .i_err_inject(i_err_inject), .i_err_bit(i_err_bit),
    .o_err_count(o_err_count), .o_cfg_busy(o_cfg_busy)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  // reference model: queue of slipped words, config as plain integers
  logic [W-1:0] m_prev;
  logic [W-1:0] w_q[$];
  int m_s, m_d, m_p, m_k, m_cnt, m_busy;
  logic [W-1:0] exp_rx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = '0;
    w_q.delete();
    for (int i = 0; i < 16; i++) w_q.push_back('0);
    m_s = 0; m_d = 0; m_p = 0; m_k = 0; m_cnt = 0; m_busy = 0;
    exp_rx = '0;
  endtask

  task automatic step();
    logic [W-1:0]   mask;
    logic [2*W-1:0] cat;
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      model_reset();
    end else begin
      mask = '0;
      if (i_err_inject) mask[i_err_bit] = 1'b1;
      if (m_p != 0 && (m_k % m_p) == m_p - 1) mask[(m_k / m_p) % W] = 1'b1;
      cat = {m_prev, i_tx_pma_data} >> m_s;
      w_q.push_back(cat[W-1:0]);
      void'(w_q.pop_front());
      exp_rx = w_q[w_q.size() - 1 - m_d] ^ mask;
      if (mask != '0 && m_cnt < 65535) m_cnt++;
      if (m_p != 0) m_k++;
      m_prev = i_tx_pma_data;
      if (i_cfg_load) begin
        m_s = (i_cfg_shift > 31) ? 31 : int'(i_cfg_shift);
        m_d = (i_cfg_delay > MD) ? MD : int'(i_cfg_delay);
        m_p = int'(i_err_period);
        m_k = 0;
        m_busy = MD + 2;
      end else if (m_busy > 0) begin
        m_busy--;
      end
    end
    check("rx", 64'(o_rx_pma_data), 64'(exp_rx));
    check("err_count", 64'(o_err_count), 64'(m_cnt));
    check("busy", 64'(o_cfg_busy), 64'(m_busy > 0));
  endtask

  task automatic load_cfg(input int s, input int d, input int p);
    i_cfg_load   = 1'b1;
    i_cfg_shift  = 5'(s);
    i_cfg_delay  = 4'(d);
    i_err_period = WP'(p);
    step();
    i_cfg_load   = 1'b0;
  endtask

  initial begin
    int busy_seen;
    int flips;
    reset = 1'b1; i_tx_pma_data = '0; i_cfg_load = 1'b0; i_cfg_shift = '0;
    i_cfg_delay = '0; i_err_period = '0; i_err_inject = 1'b0; i_err_bit = '0;
    model_reset();

    // 1: reset state, then straight pass-through
    repeat (3) step();
    check("reset_rx", 64'(o_rx_pma_data), 64'd0);
    check("reset_cnt", 64'(o_err_count), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      i_tx_pma_data = W'(i);
      step();
      check("t1_pass", 64'(o_rx_pma_data), 64'(i));
    end

    // 2: one-bit slip
    i_tx_pma_data = '0;
    load_cfg(1, 0, 0);
    i_tx_pma_data = 32'h0000_0001; step();
    i_tx_pma_data = 32'h0000_0000; step();
    check("t2_slip", 64'(o_rx_pma_data), 64'h8000_0000);

    // 3: delay 5 and busy window length
    load_cfg(0, 5, 0);
    busy_seen = int'(o_cfg_busy);
    repeat (12) begin step(); busy_seen += int'(o_cfg_busy); end
    check("t3_busy_len", 64'(busy_seen), 64'd10);
    i_tx_pma_data = 32'hA5A5_A5A5; step();
    check("t3_early", 64'(o_rx_pma_data), 64'd0);
    i_tx_pma_data = '0;
    for (int j = 1; j <= 8; j++) begin
      step();
      check("t3_delay", 64'(o_rx_pma_data), (j == 5) ? 64'hA5A5_A5A5 : 64'd0);
    end

    // 4: one-shot injection
    load_cfg(0, 0, 0);
    repeat (3) step();
    i_err_inject = 1'b1; i_err_bit = 5'd7; step();
    i_err_inject = 1'b0;
    check("t4_word", 64'(o_rx_pma_data), 64'h0000_0080);
    check("t4_cnt", 64'(o_err_count), 64'd1);
    step();
    check("t4_once", 64'(o_rx_pma_data), 64'd0);

    // 5: periodic injection, then coincident one-shot
    load_cfg(0, 0, 4);
    flips = 0;
    for (int j = 0; j < 40; j++) begin
      step();
      if (o_rx_pma_data != '0) begin
        check("t5_bit", 64'(o_rx_pma_data), 64'd1 << (j / 4));
        flips++;
      end
    end
    check("t5_flips", 64'(flips), 64'd10);
    check("t5_cnt", 64'(o_err_count), 64'd11);
    repeat (3) step();
    i_err_inject = 1'b1; i_err_bit = 5'd10; step();
    i_err_inject = 1'b0;
    check("t5_shared", 64'(o_rx_pma_data), 64'h0000_0400);
    check("t5_shared_cnt", 64'(o_err_count), 64'd12);

    // random traffic with random config (includes clamped delays)
    for (int r = 0; r < 400; r++) begin
      i_tx_pma_data = $urandom;
      i_err_inject  = ($urandom_range(7, 0) == 0);
      i_err_bit     = 5'($urandom_range(31, 0));
      i_cfg_load    = (r % 40 == 0);
      i_cfg_shift   = 5'($urandom_range(31, 0));
      i_cfg_delay   = 4'($urandom_range(15, 0));
      i_err_period  = WP'($urandom_range(6, 0));
      step();
    end
    i_cfg_load = 1'b0; i_err_inject = 1'b0;

    // 5b: every word corrupted -> counter saturates
    i_tx_pma_data = '0;
    load_cfg(0, 0, 1);
    repeat (70000) step();
    check("t5_sat", 64'(o_err_count), 64'hFFFF);

    // 6: reset in the middle of delayed traffic
    load_cfg(3, 5, 5);
    repeat (20) begin i_tx_pma_data = $urandom; step(); end
    reset = 1'b1; step();
    reset = 1'b0; i_tx_pma_data = '0;
    for (int j = 0; j < 10; j++) begin
      step();
      check("t6_clear", 64'(o_rx_pma_data), 64'd0);
    end
    check("t6_cnt", 64'(o_err_count), 64'd0);
    for (int i = 1; i <= 5; i++) begin
      i_tx_pma_data = W'(i * 3);
      step();
      check("t6_defaults", 64'(o_rx_pma_data), 64'(i * 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
